buf_stream_ctrl: RTL and testbench



---
 rtl/buf_stream_ctrl.sv | 133 +++++++++++++
 tb/tb_buf_stream_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_stream_ctrl.sv
// Frame controller: captures one AXI4-Stream frame into a single-port line buffer,
// then replays it through the buffer's combinational read port.
module buf_stream_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_DEPTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [17:0]           frame_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  buf_ce,
  output logic                  buf_we,
  output logic [17:0]           buf_addr,
  output logic [DATA_WIDTH-1:0] buf_d,
  input  logic [DATA_WIDTH-1:0] buf_q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [17:0] len;
  logic [17:0] wr_ptr;
  logic [17:0] rd_ptr;
  logic        len_ok;
  logic        s_hs;
  logic        m_hs;
  logic        fill_last;
  logic        drain_last;

  assign len_ok     = (frame_len != 18'd0) && (frame_len <= 18'(DATA_DEPTH));
  assign s_hs       = (state == FILL) && s_axis_tvalid;
  assign m_hs       = (state == DRAIN) && m_axis_tready;
  assign fill_last  = (wr_ptr == len - 18'd1);
  assign drain_last = (rd_ptr == len - 18'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The frame length is fixed by start; tlast is only cross-checked against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      len    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len    <= frame_len;
              wr_ptr <= '0;
              err    <= 1'b0;
            end else begin
              err    <= 1'b1;
            end
          end
        end
        FILL: begin
          if (s_hs) begin
            wr_ptr <= wr_ptr + 18'd1;
            if (s_axis_tlast != fill_last) err <= 1'b1;
            if (fill_last) rd_ptr <= '0;
          end
        end
        DRAIN: begin
          if (m_hs) rd_ptr <= rd_ptr + 18'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && len_ok) state_next = FILL;
      FILL:    if (s_hs && fill_last) state_next = DRAIN;
      DRAIN:   if (m_hs && drain_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer address/data are forced to zero whenever the buffer is not enabled.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    buf_ce        = 1'b0;
    buf_we        = 1'b0;
    buf_addr      = '0;
    buf_d         = '0;
    done          = 1'b0;
    busy          = (state != IDLE);
    case (state)
      FILL: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          buf_ce   = 1'b1;
          buf_we   = 1'b1;
          buf_addr = wr_ptr;
          buf_d    = s_axis_tdata;
        end
      end
      DRAIN: begin
        buf_ce        = 1'b1;
        buf_addr      = rd_ptr;
        m_axis_tdata  = buf_q;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = drain_last;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_buf_stream_ctrl.sv
// Self-checking bench for buf_stream_ctrl: scoreboard of expected buffer writes and
// output beats, with a behavioural line buffer model attached to the buffer port.
module tb_buf_stream_ctrl;

  localparam int DW = 24;
  localparam int DEPTH = 24;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [17:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [17:0]   frame_len;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          buf_ce;
  logic          buf_we;
  logic [17:0]   buf_addr;
  logic [DW-1:0] buf_d;
  logic [DW-1:0] buf_q;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_count = 0;
  int ready_mode = 0;

  beat_t         oq[$];
  wr_t           wq[$];
  logic [DW-1:0] beat_data [DEPTH];
  logic [DW-1:0] mem [DEPTH];

  buf_stream_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .buf_ce(buf_ce), .buf_we(buf_we), .buf_addr(buf_addr), .buf_d(buf_d),
    .buf_q(buf_q), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line buffer model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (buf_ce && buf_we && buf_addr < 18'(DEPTH)) mem[buf_addr] <= buf_d;
  end
  assign buf_q = (buf_ce && !buf_we && buf_addr < 18'(DEPTH)) ? mem[buf_addr] : '0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Write monitor: every buffer write must match the next expected address/data.
  always @(negedge clk) begin
    if (!rst && buf_ce && buf_we) begin
      if (wq.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        checkOutput("write_addr", buf_addr, wq[0].addr);
        checkOutput("write_data", buf_d, wq[0].data);
        void'(wq.pop_front());
      end
    end
  end

  // Output monitor: a valid beat must equal the queue head (also while stalled).
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid) begin
      if (oq.size() == 0) begin
        checkOutput("unexpected_out_beat", 1, 0);
      end else begin
        checkOutput("out_data", m_axis_tdata, oq[0].data);
        checkOutput("out_last", m_axis_tlast, oq[0].last);
        if (m_axis_tready) void'(oq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // Downstream ready: 0 = always ready, 1 = random gaps, 2 = held off.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 2) != 0);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic startFrame(input int fl);
    start = 1'b1;
    frame_len = 18'(fl);
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic sendBeat(input logic [DW-1:0] d, input logic l, input bit poke);
    int waitc = 0;
    s_axis_tdata = d;
    s_axis_tlast = l;
    s_axis_tvalid = 1'b1;
    if (poke) begin
      start = 1'b1;
      frame_len = 18'd7;
    end
    @(negedge clk);
    while (!s_axis_tready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!s_axis_tready) checkOutput("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    start = 1'b0;
  endtask

  task automatic pushExpected(input int n);
    for (int i = 0; i < n; i++) begin
      oq.push_back('{last: (i == n - 1), data: beat_data[i]});
      wq.push_back('{addr: 18'(i), data: beat_data[i]});
    end
  endtask

  // One complete frame: the frame length alone defines the output, tlast only flags err.
  task automatic applyStimulus(input int n, input int last_idx, input bit stalls,
                               input int poke_beat, input bit check_timing);
    int  base_done;
    int  waitc = 0;
    bit  exp_err = (last_idx != n - 1);
    pushExpected(n);
    base_done = done_count;
    startFrame(n);
    checkOutput("busy_after_start", busy, 1);
    checkOutput("err_cleared_on_start", err, 0);
    for (int i = 0; i < n; i++) begin
      if (stalls) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      sendBeat(beat_data[i], (i == last_idx), (i == poke_beat));
    end
    while (done_count == base_done && waitc < 1000) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    if (done_count == base_done) begin
      checkOutput("done_timeout", 0, 1);
    end else begin
      if (check_timing) checkOutput("done_latency", done_cyc - start_cyc, 2 * n);
      @(posedge clk);
      #1;
      checkOutput("done_pulse_width", done, 0);
      checkOutput("busy_after_done", busy, 0);
      checkOutput("err_after_frame", err, exp_err);
      checkOutput("out_queue_drained", oq.size(), 0);
      checkOutput("write_queue_drained", wq.size(), 0);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, {s_axis_tready, m_axis_tvalid, m_axis_tlast, buf_ce,
                                 buf_we, busy, done, err}, 0);
    checkOutput({tag, "_buses"}, {m_axis_tdata, buf_d}, 0);
    checkOutput({tag, "_addr"}, buf_addr, 0);
  endtask

  initial begin
    int n;
    int li;
    rst = 1'b1;
    start = 1'b0;
    frame_len = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleOutputs("reset_state");

    // Basic 4-beat frame with exact latency.
    for (int i = 0; i < 4; i++) beat_data[i] = 24'h000011 * 24'(i + 1);
    applyStimulus(4, 3, 1'b0, -1, 1'b1);

    // Single-beat frame.
    beat_data[0] = 24'hABCDEF;
    applyStimulus(1, 0, 1'b0, -1, 1'b1);

    // Full depth with stalls on both sides.
    ready_mode = 1;
    for (int i = 0; i < DEPTH; i++) beat_data[i] = 24'($urandom);
    applyStimulus(DEPTH, DEPTH - 1, 1'b1, -1, 1'b0);
    ready_mode = 0;

    // Early tlast: all three beats still stored and replayed, err raised.
    for (int i = 0; i < 3; i++) beat_data[i] = 24'($urandom);
    applyStimulus(3, 1, 1'b0, -1, 1'b0);

    // Missing tlast on the final beat.
    for (int i = 0; i < 2; i++) beat_data[i] = 24'($urandom);
    applyStimulus(2, -1, 1'b0, -1, 1'b0);

    // Illegal lengths leave the controller idle with err set.
    startFrame(0);
    checkOutput("illegal0_err", err, 1);
    checkOutput("illegal0_busy", busy, 0);
    checkOutput("illegal0_sready", s_axis_tready, 0);
    startFrame(DEPTH + 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("illegal25_err", err, 1);
    checkOutput("illegal25_busy", busy, 0);
    checkOutput("illegal25_sready", s_axis_tready, 0);

    // Start pulsed mid-FILL with another length is ignored.
    for (int i = 0; i < 5; i++) beat_data[i] = 24'($urandom);
    applyStimulus(5, 4, 1'b0, 2, 1'b1);

    // Random frames.
    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, DEPTH);
      li = ($urandom_range(0, 1) != 0) ? n - 1 : int'($urandom_range(0, DEPTH));
      for (int i = 0; i < n; i++) beat_data[i] = 24'($urandom);
      applyStimulus(n, li, 1'b1, -1, 1'b0);
    end

    // Reset in the middle of DRAIN while the output is stalled.
    ready_mode = 2;
    for (int i = 0; i < 5; i++) beat_data[i] = 24'($urandom);
    pushExpected(5);
    startFrame(5);
    for (int i = 0; i < 5; i++) sendBeat(beat_data[i], (i == 2), 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("predrain_err", err, 1);
    checkOutput("predrain_valid", m_axis_tvalid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkIdleOutputs("in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    oq.delete();
    wq.delete();
    ready_mode = 0;
    checkIdleOutputs("after_reset");
    @(posedge clk);
    #1;
    checkIdleOutputs("idle_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
